// File: rtl/demux_tdm.sv
// demux_tdm: TDM receive demultiplexer; steers each valid word into its channel register.
// Revision: 1.0
`default_nettype none

module demux_tdm #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [N_CH*W-1:0] dout,
  output logic [N_CH-1:0]   dout_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] ch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= HUNT;
      ch         <= '0;
      dout       <= '0;
      dout_valid <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      dout_valid <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (sync) begin
              dout[W-1:0]   <= din;
              dout_valid[0] <= 1'b1;
              ch            <= CW'(1);
              state         <= RUN;
              locked        <= 1'b1;
            end
          end
          RUN: begin
            if (sync) begin
              // A sync anywhere but the frame boundary restarts the frame at channel 0.
              sync_err      <= (ch != '0);
              dout[W-1:0]   <= din;
              dout_valid[0] <= 1'b1;
              ch            <= CW'(1);
            end else if (ch != '0) begin
              for (int k = 1; k < N_CH; k++) begin
                if (ch == CW'(k)) begin
                  dout[k*W +: W] <= din;
                  dout_valid[k]  <= 1'b1;
                end
              end
              if (ch == LAST_CH) begin
                frame_done <= 1'b1;
                ch         <= '0;
              end else begin
                ch <= ch + CW'(1);
              end
            end else begin
              sync_err <= 1'b1;
              ch       <= '0;
              state    <= HUNT;
              locked   <= 1'b0;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            ch     <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
